// File: rtl/ssc_acia_rx.sv
// Receive half of a 6551-compatible ACIA: 16x oversampled deframer for 5-8 data bits,
// optional parity and one stop bit, with RDRF/overrun/framing/parity status.
module ssc_acia_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int OVERSAMPLE  = 16
) (
  input  logic       CLK_14M,
  input  logic       RESET,
  input  logic       BAUD16_CE,
  input  logic       RXD,
  input  logic [1:0] WORD_LEN,
  input  logic       PARITY_EN,
  input  logic [1:0] PARITY_MODE,
  input  logic       RD_DATA,
  output logic [7:0] RX_DATA,
  output logic       RDRF,
  output logic       OVERRUN,
  output logic       FRAMING_ERR,
  output logic       PARITY_ERR,
  output logic       RX_BUSY
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic [TW-1:0]          tick_cnt;
  logic [2:0]             bit_idx;
  logic                   armed;
  logic [1:0]             wl_q;
  logic                   par_en_q;
  logic [1:0]             pmode_q;
  logic [7:0]             shift_q;
  logic                   pe_q;
  logic [2:0]             last_idx;
  logic                   start_det, start_ok, bit_smp, par_smp, frame_done, tick_clr;

  function automatic logic parity_err(input logic [1:0] mode, input logic [7:0] d,
                                      input logic pbit);
    case (mode)
      2'b00:   return ~^{d, pbit};
      2'b01:   return ^{d, pbit};
      2'b10:   return ~pbit;
      default: return pbit;
    endcase
  endfunction

  assign rxs      = sync_q[SYNC_STAGES-1];
  assign last_idx = 3'd7 - {1'b0, wl_q};
  assign RX_BUSY  = (state != S_IDLE);

  always_ff @(posedge CLK_14M) begin
    if (RESET) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], RXD};
  end

  always_ff @(posedge CLK_14M) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_det  = 1'b0;
    start_ok   = 1'b0;
    bit_smp    = 1'b0;
    par_smp    = 1'b0;
    frame_done = 1'b0;
    if (BAUD16_CE) begin
      case (state)
        S_IDLE: if (armed && !rxs) begin
          state_next = S_START;
          start_det  = 1'b1;
        end
        S_START: if (tick_cnt == MID_TICK) begin
          if (!rxs) begin
            state_next = S_DATA;
            start_ok   = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end
        S_DATA: if (tick_cnt == LAST_TICK) begin
          bit_smp = 1'b1;
          if (bit_idx == last_idx) state_next = par_en_q ? S_PARITY : S_STOP;
        end
        S_PARITY: if (tick_cnt == LAST_TICK) begin
          par_smp    = 1'b1;
          state_next = S_STOP;
        end
        S_STOP: if (tick_cnt == LAST_TICK) begin
          frame_done = 1'b1;
          state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
    tick_clr = start_det | start_ok | bit_smp | par_smp | frame_done;
  end

  // Control: tick/bit counters, break re-arm, and per-frame config snapshot
  always_ff @(posedge CLK_14M) begin
    if (RESET) begin
      tick_cnt <= '0;
      bit_idx  <= '0;
      armed    <= 1'b0;
      wl_q     <= '0;
      par_en_q <= 1'b0;
      pmode_q  <= '0;
    end else begin
      if (state == S_IDLE && rxs) armed <= 1'b1;
      if (BAUD16_CE) begin
        if (tick_clr || state == S_IDLE) tick_cnt <= '0;
        else                             tick_cnt <= tick_cnt + 1'b1;
        if (start_ok)     bit_idx <= '0;
        else if (bit_smp) bit_idx <= bit_idx + 3'd1;
        if (frame_done) armed <= rxs;
      end
      if (start_det) begin
        wl_q     <= WORD_LEN;
        par_en_q <= PARITY_EN;
        pmode_q  <= PARITY_MODE;
      end
    end
  end

  always_ff @(posedge CLK_14M) begin
    if (start_ok) begin
      shift_q <= '0;
      pe_q    <= 1'b0;
    end else begin
      if (bit_smp) shift_q[bit_idx] <= rxs;
      if (par_smp) pe_q <= parity_err(pmode_q, shift_q, rxs);
    end
  end

  // A completion coinciding with a CPU read behaves as if the register were empty
  always_ff @(posedge CLK_14M) begin
    if (RESET) begin
      RX_DATA     <= '0;
      RDRF        <= 1'b0;
      OVERRUN     <= 1'b0;
      FRAMING_ERR <= 1'b0;
      PARITY_ERR  <= 1'b0;
    end else if (frame_done && (!RDRF || RD_DATA)) begin
      RX_DATA     <= shift_q;
      FRAMING_ERR <= ~rxs;
      PARITY_ERR  <= pe_q;
      RDRF        <= 1'b1;
      if (RD_DATA) OVERRUN <= 1'b0;
    end else if (frame_done) begin
      OVERRUN <= 1'b1;
    end else if (RD_DATA) begin
      RDRF        <= 1'b0;
      OVERRUN     <= 1'b0;
      FRAMING_ERR <= 1'b0;
      PARITY_ERR  <= 1'b0;
    end
  end

endmodule
